// File: rtl/window_addr_gen.sv
// Sliding-window tap address generator: walks a KxK window over a frame and emits one tap address per accepted cycle.
// Optional edge-replicate clamping of tap coordinates is enabled by defining WINDOW_CLAMP_EN.
module window_addr_gen #(
    parameter int ROW_W    = 11,
    parameter int COL_W    = 11,
    parameter int K        = 5,
    parameter int STRIDE_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ROW_W-1:0]         rowMax,
    input  logic [COL_W-1:0]         colMax,
    input  logic [STRIDE_W-1:0]      stride,
    input  logic                     addr_ready,
    output logic [ROW_W+COL_W-1:0]   address,
    output logic                     addr_valid,
    output logic                     in_bounds,
    output logic                     win_first,
    output logic                     win_last,
    output logic [ROW_W-1:0]         row,
    output logic [COL_W-1:0]         col,
    output logic                     busy,
    output logic                     done
);

    localparam int R     = (K - 1) / 2;
    localparam int CNT_W = $clog2(K);
    localparam int AW    = ROW_W + COL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ROW_W-1:0]          rmax_q, rmax_d;
    logic [COL_W-1:0]          cmax_q, cmax_d;
    logic [STRIDE_W-1:0]       stride_q, stride_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [CNT_W-1:0]          dr_q, dr_d;
    logic [CNT_W-1:0]          dc_q, dc_d;
    logic signed [ROW_W:0]     tr_q, tr_d;
    logic signed [COL_W:0]     tc_q, tc_d;
    logic [AW-1:0]             address_q, address_d;
    logic                      addr_valid_q, addr_valid_d;
    logic                      in_bounds_q, in_bounds_d;
    logic                      win_first_q, win_first_d;
    logic                      win_last_q, win_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [ROW_W+1:0]   tr_w;
    logic signed [COL_W+1:0]   tc_w;
    logic [ROW_W-1:0]          tr_eff;
    logic [COL_W-1:0]          tc_eff;
    logic [ROW_W:0]            row_sum;
    logic [COL_W:0]            col_sum;
    logic                      load_tap;
    logic                      clear_tap;

    function automatic logic signed [ROW_W+1:0] row_base(input logic [ROW_W-1:0] r);
        row_base = $signed({2'b00, r}) - $signed((ROW_W+2)'(R));
    endfunction

    function automatic logic signed [COL_W+1:0] col_base(input logic [COL_W-1:0] c);
        col_base = $signed({2'b00, c}) - $signed((COL_W+2)'(R));
    endfunction

    function automatic logic [ROW_W-1:0] clamp_row(input logic signed [ROW_W+1:0] t,
                                                   input logic [ROW_W-1:0] lim);
        if (t[ROW_W+1])                       clamp_row = '0;
        else if (t >= $signed({2'b00, lim}))  clamp_row = lim - 1'b1;
        else                                  clamp_row = t[ROW_W-1:0];
    endfunction

    function automatic logic [COL_W-1:0] clamp_col(input logic signed [COL_W+1:0] t,
                                                   input logic [COL_W-1:0] lim);
        if (t[COL_W+1])                       clamp_col = '0;
        else if (t >= $signed({2'b00, lim}))  clamp_col = lim - 1'b1;
        else                                  clamp_col = t[COL_W-1:0];
    endfunction

    assign row_sum = {1'b0, row_q} + (ROW_W+1)'(stride_q);
    assign col_sum = {1'b0, col_q} + (COL_W+1)'(stride_q);

    always_comb begin
        state_d      = state_q;
        rmax_d       = rmax_q;
        cmax_d       = cmax_q;
        stride_d     = stride_q;
        row_d        = row_q;
        col_d        = col_q;
        dr_d         = dr_q;
        dc_d         = dc_q;
        tr_d         = tr_q;
        tc_d         = tc_q;
        address_d    = address_q;
        addr_valid_d = addr_valid_q;
        in_bounds_d  = in_bounds_q;
        win_first_d  = win_first_q;
        win_last_d   = win_last_q;
        busy_d       = busy_q;
        done_d       = done_q;
        tr_w         = {tr_q[ROW_W], tr_q};
        tc_w         = {tc_q[COL_W], tc_q};
        load_tap     = 1'b0;
        clear_tap    = 1'b0;

        if (abort) begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            row_d        = '0;
            col_d        = '0;
            dr_d         = '0;
            dc_d         = '0;
            clear_tap    = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        rmax_d   = rowMax;
                        cmax_d   = colMax;
                        stride_d = (stride == '0) ? STRIDE_W'(1) : stride;
                        row_d    = '0;
                        col_d    = '0;
                        dr_d     = '0;
                        dc_d     = '0;
                        if ((rowMax == '0) || (colMax == '0)) begin
                            state_d      = DONE;
                            addr_valid_d = 1'b0;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                        end else begin
                            state_d      = SCAN;
                            addr_valid_d = 1'b1;
                            busy_d       = 1'b1;
                            done_d       = 1'b0;
                            tr_w         = row_base('0);
                            tc_w         = col_base('0);
                            load_tap     = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Column offset is the outer loop, row offset the inner one.
                    if (addr_valid_q && addr_ready) begin
                        if (dr_q != CNT_LAST) begin
                            dr_d     = dr_q + 1'b1;
                            tr_w     = tr_w + (ROW_W+2)'(1);
                            load_tap = 1'b1;
                        end else begin
                            dr_d = '0;
                            tr_w = row_base(row_q);
                            if (dc_q != CNT_LAST) begin
                                dc_d     = dc_q + 1'b1;
                                tc_w     = tc_w + (COL_W+2)'(1);
                                load_tap = 1'b1;
                            end else begin
                                dc_d = '0;
                                if (col_sum < {1'b0, cmax_q}) begin
                                    col_d    = col_sum[COL_W-1:0];
                                    tc_w     = col_base(col_sum[COL_W-1:0]);
                                    load_tap = 1'b1;
                                end else if (row_sum < {1'b0, rmax_q}) begin
                                    col_d    = '0;
                                    row_d    = row_sum[ROW_W-1:0];
                                    tr_w     = row_base(row_sum[ROW_W-1:0]);
                                    tc_w     = col_base('0);
                                    load_tap = 1'b1;
                                end else begin
                                    state_d      = DONE;
                                    addr_valid_d = 1'b0;
                                    busy_d       = 1'b0;
                                    done_d       = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d      = IDLE;
                    addr_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b0;
                end
            endcase
        end

`ifdef WINDOW_CLAMP_EN
        tr_eff = clamp_row(tr_w, rmax_d);
        tc_eff = clamp_col(tc_w, cmax_d);
`else
        tr_eff = tr_w[ROW_W-1:0];
        tc_eff = tc_w[COL_W-1:0];
`endif

        if (clear_tap) begin
            tr_d        = '0;
            tc_d        = '0;
            address_d   = '0;
            in_bounds_d = 1'b0;
            win_first_d = 1'b0;
            win_last_d  = 1'b0;
        end else if (load_tap) begin
            tr_d        = tr_w[ROW_W:0];
            tc_d        = tc_w[COL_W:0];
            address_d   = AW'(tr_eff) * AW'(cmax_d) + AW'(tc_eff);
            // Bounds test always uses the unclamped coordinates.
            in_bounds_d = !tr_w[ROW_W+1] && (tr_w < $signed({2'b00, rmax_d})) &&
                          !tc_w[COL_W+1] && (tc_w < $signed({2'b00, cmax_d}));
            win_first_d = (dr_d == '0) && (dc_d == '0);
            win_last_d  = (dr_d == CNT_LAST) && (dc_d == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rmax_q       <= '0;
            cmax_q       <= '0;
            stride_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dr_q         <= '0;
            dc_q         <= '0;
            tr_q         <= '0;
            tc_q         <= '0;
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            in_bounds_q  <= 1'b0;
            win_first_q  <= 1'b0;
            win_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rmax_q       <= rmax_d;
            cmax_q       <= cmax_d;
            stride_q     <= stride_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dr_q         <= dr_d;
            dc_q         <= dc_d;
            tr_q         <= tr_d;
            tc_q         <= tc_d;
            address_q    <= address_d;
            addr_valid_q <= addr_valid_d;
            in_bounds_q  <= in_bounds_d;
            win_first_q  <= win_first_d;
            win_last_q   <= win_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign address    = address_q;
    assign addr_valid = addr_valid_q;
    assign in_bounds  = in_bounds_q;
    assign win_first  = win_first_q;
    assign win_last   = win_last_q;
    assign row        = row_q;
    assign col        = col_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
